// File: rtl/iq_mixer_dac_if.sv
// iq_mixer_dac_if: NCO stream, baseband I/Q handshake, flag control and DAC output of the mixer
interface iq_mixer_dac_if #(
  parameter int DW = 13,
  parameter int SW = 13,
  parameter int OW = 14
);
  logic nco_valid_i;
  logic signed [DW-1:0] fsin_i, fcos_i;
  logic signed [SW-1:0] i_data_i, q_data_i;
  logic iq_valid_i, iq_ready_o, flags_clr_i;
  logic [OW-1:0] dac_o;
  logic dac_valid_o, sat_o, underrun_o;
  modport master (
    output nco_valid_i, fsin_i, fcos_i, i_data_i, q_data_i, iq_valid_i, flags_clr_i,
    input  iq_ready_o, dac_o, dac_valid_o, sat_o, underrun_o
  );
  modport slave (
    input  nco_valid_i, fsin_i, fcos_i, i_data_i, q_data_i, iq_valid_i, flags_clr_i,
    output iq_ready_o, dac_o, dac_valid_o, sat_o, underrun_o
  );
endinterface

// File: rtl/iq_mixer_dac.sv
// iq_mixer_dac: zero-order-hold I/Q upsampler mixing I*cos - Q*sin into a rounded, saturated DAC stream
module iq_mixer_dac #(
  parameter int DW = 13,
  parameter int SW = 13,
  parameter int OW = 14,
  parameter int SHIFT = 11,
  parameter int HOLD = 4,
  parameter int OFFSET_BINARY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  iq_mixer_dac_if.slave bus
);
  localparam int PW = DW + SW;
  localparam int AW = PW + 2;
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [OW-1:0] FLIP = OFFSET_BINARY != 0 ? {1'b1, {(OW-1){1'b0}}} : '0;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic signed [SW-1:0] cur_i, cur_q, nxt_i, nxt_q;
  logic nxt_full, accept, beat, last, load, underrun_set;
  logic [CW-1:0] cnt;
  logic signed [PW-1:0] p_i, p_q;
  logic signed [PW:0] sum;
  logic signed [AW-1:0] sh;
  logic v1, v2, hi, lo, dac_valid, sat, underrun;
  logic [OW-1:0] dac, sat_val;
  assign accept = bus.iq_valid_i & ~nxt_full;
  assign beat = clken & bus.nco_valid_i;
  assign last = cnt == CW'(HOLD - 1);
  // accept needs nxt empty and a transfer needs nxt full, so the two never collide
  always_comb begin
    load = state == IDLE ? clken & nxt_full : beat & last & nxt_full;
    underrun_set = (state == RUN) & beat & last & ~nxt_full;
    state_d = load ? RUN : underrun_set ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nxt_full <= 1'b0;
      nxt_i <= '0;
      nxt_q <= '0;
      cur_i <= '0;
      cur_q <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        nxt_i <= bus.i_data_i;
        nxt_q <= bus.q_data_i;
      end
      nxt_full <= accept | (nxt_full & ~load);
      if (load | underrun_set) begin
        cur_i <= load ? nxt_i : '0;
        cur_q <= load ? nxt_q : '0;
      end
      if (load) cnt <= '0;
      else if ((state == RUN) & beat) cnt <= last ? '0 : cnt + CW'(1);
    end
  end
  // round half up, then clip to the DAC range
  always_comb begin
    sh = (AW'(sum) + AW'(2 ** (SHIFT - 1))) >>> SHIFT;
    hi = sh > AW'(2 ** (OW - 1) - 1);
    lo = sh < AW'(-(2 ** (OW - 1)));
    sat_val = hi ? {1'b0, {(OW-1){1'b1}}} : lo ? {1'b1, {(OW-1){1'b0}}} : sh[OW-1:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_i <= '0;
      p_q <= '0;
      sum <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      dac <= FLIP;
      dac_valid <= 1'b0;
      sat <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (clken) begin
        p_i <= PW'(cur_i) * PW'(bus.fcos_i);
        p_q <= PW'(cur_q) * PW'(bus.fsin_i);
        sum <= (PW+1)'(p_i) - (PW+1)'(p_q);
        v1 <= bus.nco_valid_i;
        v2 <= v1;
      end
      if (clken & v2) dac <= sat_val ^ FLIP;
      dac_valid <= clken & v2;
      sat <= (clken & v2 & (hi | lo)) | (sat & ~bus.flags_clr_i);
      underrun <= underrun_set | (underrun & ~bus.flags_clr_i);
    end
  end
  assign bus.iq_ready_o = ~nxt_full;
  assign bus.dac_o = dac;
  assign bus.dac_valid_o = dac_valid;
  assign bus.sat_o = sat;
  assign bus.underrun_o = underrun;
endmodule
